// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - two-stage pipelined carry-lookahead adder/subtractor
//
// Optional flags: define CLA_PIPE_FLAGS_EN to generate the ovf/zero logic.
// Without it, ovf and zero are tied to 0. sum, cout, latency and handshake
// behave the same either way.
//
// Parameters:
//   WIDTH  operand/result width, a multiple of GROUP, 4..64
//   GROUP  bits per lookahead group, 2..8
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operand beat handshake (in_ready is combinational from out_ready)
//   a, b, cin, sub        operands; sub=1 computes a-b as a+~b+1 and ignores cin
//   out_valid/out_ready   result beat handshake
//   sum, cout, ovf, zero  result, carry out of the MSB, signed overflow, sum==0
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64 || GROUP < 2 || GROUP > 8) begin : g_bad_params
      $fatal(1, "cla_adder_pipe: illegal WIDTH/GROUP combination");
    end
  endgenerate

  // Handshake: a stage may load whenever the stage after it is empty or moving.
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: bit and group propagate/generate.
  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic [NG-1:0]    pg_in, gg_in;
  logic             c0_in;

  always_comb begin
    logic term;
    term  = 1'b0;
    b_eff = sub ? ~b : b;
    c0_in = sub ? 1'b1 : cin;
    p_in  = a ^ b_eff;
    g_in  = a & b_eff;
    pg_in = '0;
    gg_in = '0;
    for (int k = 0; k < NG; k++) begin
      pg_in[k] = &p_in[k*GROUP +: GROUP];
      // Group generate as a flat OR of g[j] & p[j+1..top] terms.
      for (int j = 0; j < GROUP; j++) begin
        term = g_in[k*GROUP + j];
        for (int m = j + 1; m < GROUP; m++) term = term & p_in[k*GROUP + m];
        gg_in[k] = gg_in[k] | term;
      end
    end
  end

  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NG-1:0]    s1_pg, s1_gg;
  logic             s1_c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_p  <= p_in;
      s1_g  <= g_in;
      s1_pg <= pg_in;
      s1_gg <= gg_in;
      s1_c0 <= c0_in;
    end
  end

  // Stage 2: every group carry is a sum of products over the registered group
  // terms and c0, so no carry ripples from one group into the next.
  logic [NG:0]      gc;
  logic [WIDTH-1:0] bc;
  logic [WIDTH-1:0] sum_nx;

  always_comb begin
    logic term;
    term  = 1'b0;
    gc    = '0;
    bc    = '0;
    gc[0] = s1_c0;
    for (int k = 0; k < NG; k++) begin
      term = s1_c0;
      for (int m = 0; m <= k; m++) term = term & s1_pg[m];
      gc[k+1] = term;
      for (int j = 0; j <= k; j++) begin
        term = s1_gg[j];
        for (int m = j + 1; m <= k; m++) term = term & s1_pg[m];
        gc[k+1] = gc[k+1] | term;
      end
    end
    // Bit carries inside each group, flat from that group's carry-in.
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        term = gc[k];
        for (int m = 0; m < i; m++) term = term & s1_p[k*GROUP + m];
        bc[k*GROUP + i] = term;
        for (int j = 0; j < i; j++) begin
          term = s1_g[k*GROUP + j];
          for (int m = j + 1; m < i; m++) term = term & s1_p[k*GROUP + m];
          bc[k*GROUP + i] = bc[k*GROUP + i] | term;
        end
      end
    end
    sum_nx = s1_p ^ bc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= sum_nx;
        cout <= gc[NG];
      end
    end
  end

`ifdef CLA_PIPE_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      // Signed overflow: carry into the MSB differs from carry out of it.
      ovf  <= bc[WIDTH-1] ^ gc[NG];
      zero <= ~|sum_nx;
    end
  end
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
